// File: rtl/gcd_result_display_pkg.sv
// Shared constants for the GCD result display: FSM encoding, segment patterns
// and the double-dabble nibble adjust step.
package gcd_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        SHOW = 2'b10
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [4:0] BCD_ITER = 5'd16;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift
    function automatic logic [19:0] dd_adjust(input logic [19:0] bcd);
        logic [19:0] res;
        res = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gcd_result_display_if.sv
// Result/display bundle between the GCD engine side and the display block.
interface gcd_result_display_if;
    logic        done;
    logic [15:0] gcd;
    logic        busy;
    logic        valid;
    logic [3:0]  an;
    logic [6:0]  seg;

    modport master (output done, output gcd, input busy, input valid, input an, input seg);
    modport slave  (input done, input gcd, output busy, output valid, output an, output seg);
endinterface

// File: rtl/gcd_result_display_seven_seg_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern; 10..15 show blank.
module seven_seg_decode
    import gcd_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (nibble_i == 4'(i)) begin
                seg_o = SEG_DIGIT[i];
            end
        end
    end

endmodule

// File: rtl/gcd_result_display.sv
// Captures a GCD result, converts it to BCD serially and scans it onto a
// 4-digit common-anode display. Optional macro: LEADING_ZERO_BLANK_EN.
module gcd_result_display
    import gcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 17
) (
    input logic                clk,
    input logic                rst_n,
    gcd_result_display_if.slave bus
);

    state_t                 state_q;
    logic                   busy_q;
    logic                   valid_q;
    logic                   done_dly_q;
    logic                   shown_q;
    logic [REFRESH_DIV-1:0] scan_q;
    logic [15:0]            bin_q;
    logic [19:0]            bcd_q;
    logic [4:0]             iter_q;
    logic [19:0]            result_q;

    logic        done_rise;
    logic [35:0] shift_d;
    logic [1:0]  digit_idx;
    logic        overflow;
    logic [3:0]  lz_blank;
    logic [6:0]  dig_seg [4];
    logic [3:0]  an_c;
    logic [6:0]  seg_c;

    assign done_rise = bus.done & ~done_dly_q;
    assign shift_d   = {dd_adjust(bcd_q), bin_q} << 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_dly_q <= 1'b0;
            shown_q    <= 1'b0;
            scan_q     <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            result_q   <= '0;
        end else begin
            done_dly_q <= bus.done;
            scan_q     <= scan_q + 1'b1;
            // A new result always wins, even in the middle of a conversion
            if (done_rise) begin
                bin_q   <= bus.gcd;
                bcd_q   <= '0;
                iter_q  <= '0;
                state_q <= CONV;
                busy_q  <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    CONV: begin
                        bcd_q  <= shift_d[35:16];
                        bin_q  <= shift_d[15:0];
                        iter_q <= iter_q + 5'd1;
                        if (iter_q == BCD_ITER - 5'd1) begin
                            result_q <= shift_d[35:16];
                            shown_q  <= 1'b1;
                            state_q  <= SHOW;
                            busy_q   <= 1'b0;
                            valid_q  <= 1'b1;
                        end
                    end
                    IDLE, SHOW: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            seven_seg_decode u_dec (
                .nibble_i (result_q[gi*4 +: 4]),
                .seg_o    (dig_seg[gi])
            );
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    assign lz_blank[3] = (result_q[15:12] == 4'd0);
    assign lz_blank[2] = lz_blank[3] && (result_q[11:8] == 4'd0);
    assign lz_blank[1] = lz_blank[2] && (result_q[7:4] == 4'd0);
    assign lz_blank[0] = 1'b0;
`else
    assign lz_blank = 4'b0000;
`endif

    // Scan field 0..3 walks thousands..units, i.e. an[3] down to an[0]
    assign digit_idx = ~scan_q[REFRESH_DIV-1 -: 2];
    assign overflow  = (result_q[19:16] != 4'd0);

    always_comb begin
        an_c  = 4'b1111;
        seg_c = SEG_BLANK;
        if (shown_q) begin
            if (overflow) begin
                an_c[digit_idx] = 1'b0;
                seg_c           = SEG_DASH;
            end else if (!lz_blank[digit_idx]) begin
                an_c[digit_idx] = 1'b0;
                seg_c           = dig_seg[digit_idx];
            end
        end
    end

    assign bus.an  = an_c;
    assign bus.seg = seg_c;

endmodule

// File: doc/gcd_result_display.md
Name: gcd_result_display

Overview:
- Downstream consumer of the GCD engine's `done` / `gcd[15:0]` outputs.
- Captures the result on the rising edge of `done`. Converts it to BCD with a serial shift-add-3 (double-dabble) engine.
- Drives a 4-digit, time-multiplexed, common-anode 7-segment display.
- Values above 9999 show as four dashes.

Parameters:
- REFRESH_DIV, default 17: width of the free-running scan counter. The top 2 bits select the active digit, so the per-digit period is 2^(REFRESH_DIV-2) clk cycles.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- done  input  1  result-ready from the GCD engine; may stay high for several cycles
- gcd  input  16  unsigned result; sampled only on the done rising edge
- busy  output  1  high while a BCD conversion is running
- valid  output  1  high once a completed result is being displayed
- an  output  4  digit enables, active-low, an[3] = leftmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE, busy=0, valid=0, an=4'b1111, seg=7'b1111111.
  - Scan counter, done_d, shift and BCD registers cleared.
  - Reset applies in every state, including mid-conversion.
- Edge detect:
  - done_d <= done each cycle; done_rise = done & ~done_d.
  - A done level that is held high triggers only once.
- FSM states IDLE, CONV, SHOW:
  - IDLE: display blank. done_rise -> capture gcd into the shift register, clear BCD work register and iteration counter, go to CONV, busy=1.
  - CONV: one double-dabble iteration per cycle. First, add 3 to each of the 5 BCD nibbles that is ≥5. Then shift {bcd,bin} left 1. After the 16th iteration, load the result register, go to SHOW, busy=0, valid=1.
  - Latency: valid and the new digits appear 16 cycles after the capture edge.
  - SHOW: display the result register; valid stays 1. done_rise -> capture and go to CONV. valid drops to 0, but the previous result stays displayed until the new one is loaded.
  - done_rise during CONV: abort, recapture the new gcd, restart the iteration count at 0. Exactly 16 more cycles to completion.
- Width rules:
  - 5-nibble BCD work register (20 bits) covers 0..65535.
  - Iteration counter is 5 bits, terminal count 16.
  - No truncation of gcd.
- Overflow: ten-thousands nibble ≠ 0 → all four digits show a dash (seg=7'b0111111).
- Scan:
  - Scan counter increments every cycle in all states and wraps naturally.
  - counter[REFRESH_DIV-1:REFRESH_DIV-2] = 0,1,2,3 selects thousands, hundreds, tens, units on an[3], an[2], an[1], an[0].
  - Exactly one an bit is low when displaying; an=4'b1111 in IDLE.
- Decode: 0-9 use standard active-low patterns (0 → 7'b1000000, 1 → 7'b1111001, …, 9 → 7'b0010000). Nibbles 10-15 cannot occur and decode to blank.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined: leading zero digits are blanked (an bit held high for that digit), except the units digit, which always displays. 0 shows "   0"; 42 shows "  42".
- LEADING_ZERO_BLANK_EN undefined: all four digits always display; 42 shows "0042".
- The overflow dash display is unaffected by the macro.

Decomposition:
- Package gcd_disp_pkg: state encoding (IDLE=2'b00, CONV=2'b01, SHOW=2'b10), SEG_BLANK, SEG_DASH, the SEG_DIGIT[0:9] constant array, and BCD_ITER=16.
- One natural sub-module, seven_seg_decode: purely combinational, 4-bit nibble to 7-bit active-low segment pattern.
- The conversion FSM and the scan logic stay in the top module.

Test Plan (REFRESH_DIV=4 for speed):
- Reset then idle 40 cycles → an=4'b1111, seg=7'b1111111, busy=0, valid=0.
- done pulse with gcd=1234, held high 2 cycles → busy high for 16 cycles; valid=1 at capture+16; scan shows 1,2,3,4 on an[3..0]; only one retrigger-free capture.
- gcd=65535 → all digits show seg=7'b0111111. gcd=9999 → 9,9,9,9.
- gcd=0 and gcd=42 → "0000"/"0042" without the macro; "   0"/"  42" with LEADING_ZERO_BLANK_EN.
- During CONV of 1234, done rises with gcd=56 at iteration 8 → result 0056 at new capture+16; 1234 never displayed.
- rst_n low mid-CONV → next cycle all outputs at reset values; a subsequent done with gcd=7 converts normally.
